// File: rtl/train_eta_predictor.sv
`default_nettype none
// ============================================================================
// Module   : train_eta_predictor
// Brief    : Predicts ms until gate close from the S1->S2 transit time using
//            a bit-serial restoring divider. Define ETA_ROUND_EN for rounding.
// Revision : 1.0 - initial release
// ============================================================================
module train_eta_predictor #(
  parameter int TW      = 19,
  parameter int MW      = 17,
  parameter int DIST_S1 = 4167,
  parameter int DIST_S2 = 66667,
  parameter int OFFSET  = 30000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [TW-1:0] time_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [TW-1:0] time_out,
  output logic          early,
  output logic          sat,
  output logic          busy
);

  localparam int PW = TW + MW;
  localparam int RW = $clog2(DIST_S1 + 1) + 1;
  localparam int CW = $clog2(PW + 1);

  localparam logic [RW-1:0]        C_D1  = RW'(DIST_S1);
  localparam logic [MW-1:0]        C_D2  = MW'(DIST_S2);
  localparam logic signed [PW+1:0] C_OFF = (PW+2)'(OFFSET);
  localparam logic signed [PW+1:0] C_MAX = {{(PW+2-TW){1'b0}}, {TW{1'b1}}};
`ifdef ETA_ROUND_EN
  localparam logic [RW:0]          C_D1X = (RW+1)'(DIST_S1);
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    FIN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [PW-1:0]  dvd_q, dvd_d;
  logic [RW-1:0]  rem_q, rem_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [TW-1:0]  time_out_q, time_out_d;
  logic           early_q, early_d;
  logic           sat_q, sat_d;

  logic [RW-1:0]        w_rem_sh;
  logic                 w_qbit;
  logic [PW:0]          w_q;
  logic signed [PW+1:0] w_diff;

  // The dividend register shifts left and collects quotient bits at its LSB,
  // so after PW steps it holds the quotient and rem_q holds the remainder.
  always_comb begin
    w_rem_sh = {rem_q[RW-2:0], dvd_q[PW-1]};
    w_qbit   = (w_rem_sh >= C_D1);
    w_q      = {1'b0, dvd_q};
`ifdef ETA_ROUND_EN
    if ({rem_q, 1'b0} >= C_D1X) begin
      w_q = w_q + (PW+1)'(1);
    end
`endif
    w_diff = $signed({1'b0, w_q}) - C_OFF;
  end

  always_comb begin
    state_d    = state_q;
    dvd_d      = dvd_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    time_out_d = time_out_q;
    early_d    = early_q;
    sat_d      = sat_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          dvd_d   = PW'(time_in) * PW'(C_D2);
          rem_d   = '0;
          cnt_d   = '0;
          state_d = DIV;
        end
      end
      DIV: begin
        // PW shift steps followed by one settle cycle before FIN.
        if (cnt_q == CW'(PW)) begin
          state_d = FIN;
        end else begin
          rem_d = w_qbit ? (w_rem_sh - C_D1) : w_rem_sh;
          dvd_d = {dvd_q[PW-2:0], w_qbit};
          cnt_d = cnt_q + CW'(1);
        end
      end
      FIN: begin
        early_d = 1'b0;
        sat_d   = 1'b0;
        if (w_diff[PW+1]) begin
          time_out_d = '0;
          early_d    = 1'b1;
        end else if (w_diff > C_MAX) begin
          time_out_d = '1;
          sat_d      = 1'b1;
        end else begin
          time_out_d = w_diff[TW-1:0];
        end
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      dvd_q      <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      time_out_q <= '0;
      early_q    <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      dvd_q      <= dvd_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      time_out_q <= time_out_d;
      early_q    <= early_d;
      sat_q      <= sat_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign time_out  = time_out_q;
  assign early     = early_q;
  assign sat       = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_train_eta_predictor.sv
`default_nettype none
// ============================================================================
// Module   : tb_train_eta_predictor
// Brief    : Directed bench with an arithmetic reference model for the ETA
//            predictor; honours ETA_ROUND_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_train_eta_predictor;

  localparam int TW  = 19;
  localparam int MW  = 17;
  localparam int D1  = 4167;
  localparam int D2  = 66667;
  localparam int OFF = 30000;
  localparam int LAT = TW + MW + 2;
`ifdef ETA_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [TW-1:0] time_in = '0;
  logic          in_ready, out_valid, early, sat, busy;
  logic [TW-1:0] time_out;

  int n_checks = 0;
  int n_err    = 0;

  train_eta_predictor dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .time_in(time_in),
    .out_valid(out_valid), .out_ready(out_ready), .time_out(time_out),
    .early(early), .sat(sat), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic void model_eta(input longint tin, output longint t,
                                    output bit e, output bit s);
    longint p, q, r, d;
    p = tin * D2;
    q = p / D1;
    r = p % D1;
    if (RND && (2 * r >= D1)) q++;
    d = q - OFF;
    e = 1'b0;
    s = 1'b0;
    if (d < 0) begin
      t = 0; e = 1'b1;
    end else if (d > (longint'(1) << TW) - 1) begin
      t = (longint'(1) << TW) - 1; s = 1'b1;
    end else begin
      t = d;
    end
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Transaction-level reference: idle / computing / result-held.
  bit     m_init = 0, m_idle = 1, m_valid = 0, m_fresh = 1;
  int     m_cnt = 0;
  longint m_to = 0, p_to;
  bit     m_e = 0, m_s = 0, p_e, p_s;

  always @(posedge clk) begin
    if (rst) begin
      m_init <= 1; m_idle <= 1; m_valid <= 0; m_fresh <= 1;
      m_to <= 0; m_e <= 0; m_s <= 0;
    end else if (m_idle) begin
      if (in_valid) begin
        model_eta(longint'(time_in), p_to, p_e, p_s);
        m_idle <= 0;
        m_cnt  <= 0;
      end
    end else if (!m_valid) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt + 1 == LAT) begin
        m_valid <= 1; m_fresh <= 0;
        m_to <= p_to; m_e <= p_e; m_s <= p_s;
      end
    end else if (out_ready) begin
      m_valid <= 0;
      m_idle  <= 1;
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("in_ready", 64'(in_ready), 64'(m_idle));
      chk("busy", 64'(busy), 64'(!m_idle));
      chk("out_valid", 64'(out_valid), 64'(m_valid));
      if (m_valid || m_fresh) begin
        chk("time_out", 64'(time_out), 64'(m_to));
        chk("early", 64'(early), 64'(m_e));
        chk("sat", 64'(sat), 64'(m_s));
      end
    end
  end

  task automatic run(input int tin, input int exp_to, input bit exp_e,
                     input bit exp_s, input int hold);
    int k;
    @(negedge clk);
    in_valid  = 1'b1;
    time_in   = TW'(tin);
    out_ready = (hold == 0);
    @(negedge clk);
    in_valid = 1'b0;
    time_in  = TW'($urandom);
    k = 0;
    while (!out_valid && k < 100) begin
      if (k == 5) begin in_valid = 1'b1; time_in = TW'($urandom); end
      if (k == 8) in_valid = 1'b0;
      @(negedge clk);
      k++;
    end
    chk("latency", 64'(k), 64'(LAT));
    chk("lit_time_out", 64'(time_out), 64'(exp_to));
    chk("lit_early", 64'(early), 64'(exp_e));
    chk("lit_sat", 64'(sat), 64'(exp_s));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_time_out", 64'(time_out), 64'(exp_to));
      chk("hold_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_hs_in_ready", 64'(in_ready), 64'd1);
    chk("post_hs_out_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    longint t;
    bit     e, s;

    model_eta(5000, t, e, s);   chk("model_5000", 64'(t), 64'd49994);
    model_eta(2000, t, e, s);   chk("model_2000", 64'(t), RND ? 64'd1998 : 64'd1997);
    model_eta(1000, t, e, s);   chk("model_1000_early", 64'(e), 64'd1);
    model_eta(524287, t, e, s); chk("model_max_sat", 64'(s), 64'd1);

    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_time_out", 64'(time_out), 64'd0);
    rst = 1'b0;

    run(5000, 49994, 1'b0, 1'b0, 0);
    run(2000, RND ? 1998 : 1997, 1'b0, 1'b0, 0);
    run(1000, 0, 1'b1, 1'b0, 0);
    run(0, 0, 1'b1, 1'b0, 0);
    run(524287, 524287, 1'b0, 1'b1, 10);

    // Abort mid-division, then a fresh measurement.
    @(negedge clk);
    in_valid = 1'b1; time_in = TW'(5000);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_time_out", 64'(time_out), 64'd0);
    chk("abort_early", 64'(early), 64'd0);
    chk("abort_sat", 64'(sat), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    run(5000, 49994, 1'b0, 1'b0, 0);

    // Reset wins over a simultaneous accept.
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; time_in = TW'(2000);
    @(negedge clk);
    chk("rst_prio_busy", 64'(busy), 64'd0);
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("rst_prio_idle", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/train_eta_predictor.md
TRAIN_ETA_PREDICTOR -- requirements
Module: train_eta_predictor

Interface
REQ-001 The block SHALL have parameter TW, default 19: width of time_in/time_out in ms ticks.
REQ-002 The block SHALL have parameter MW, default 17: width of DIST_S2; the internal product width PW SHALL equal TW+MW.
REQ-003 The block SHALL have parameter DIST_S1, default 4167: sensor S1-to-S2 distance in cm; it SHALL be nonzero.
REQ-004 The block SHALL have parameter DIST_S2, default 66667: sensor S2-to-crossing distance in cm.
REQ-005 The block SHALL have parameter OFFSET, default 30000: gate-close lead time in ms, subtracted from the ETA.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all logic SHALL be rising-edge.
REQ-007 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 The block SHALL have port in_valid, input, 1 bit: time_in is valid.
REQ-009 The block SHALL have port in_ready, output, 1 bit: the block can accept a measurement.
REQ-010 The block SHALL have port time_in, input, TW bits: measured S1-to-S2 transit time in ms.
REQ-011 The block SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-012 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-013 The block SHALL have port time_out, output, TW bits: predicted ms until gate close.
REQ-014 The block SHALL have port early, output, 1 bit: the result was clamped to 0 because the computed value was negative.
REQ-015 The block SHALL have port sat, output, 1 bit: the result was saturated to 2^TW-1.
REQ-016 The block SHALL have port busy, output, 1 bit: a computation is in progress or a result is being held.

Function
REQ-017 Result SHALL be time_out = q - OFFSET, where q = (time_in*DIST_S2)/DIST_S1 computed as an unsigned integer; no real arithmetic is used.
REQ-018 FSM states SHALL be IDLE, DIV, FIN and DONE.
REQ-019 in_ready SHALL be 1 only in IDLE.
REQ-020 An accept is the edge where in_valid=1 and in_ready=1; on it the block SHALL register time_in*DIST_S2 (PW bits) and go to DIV.
REQ-021 DIV SHALL run a restoring divide by DIST_S1, one quotient bit per cycle, for exactly PW cycles, then go to FIN.
REQ-022 FIN SHALL last 1 cycle and SHALL subtract OFFSET from q with a signed result: if the result is < 0, time_out=0 and early=1; if the result is > 2^TW-1, time_out=2^TW-1 and sat=1; otherwise time_out=result with both flags 0; it SHALL then go to DONE.
REQ-023 In DONE, out_valid SHALL be 1 and time_out, early and sat SHALL be held stable until out_ready=1.
REQ-024 The out_valid rising edge SHALL occur exactly PW+2 cycles after the accepting edge (38 with defaults).
REQ-025 The DONE-to-IDLE transition SHALL occur on the edge where out_valid=1 and out_ready=1.
REQ-026 in_ready SHALL NOT be asserted in the same cycle as that handshake, so back-to-back measurements take at least PW+4 cycles.
REQ-027 out_ready SHALL be ignored outside DONE.
REQ-028 in_valid SHALL be ignored outside IDLE.
REQ-029 time_in SHALL be sampled only on the accept edge; later changes SHALL NOT affect the result.
REQ-030 busy SHALL be 1 when the state is not IDLE.
REQ-031 time_in=0 SHALL give q=0, so time_out=0 and early=1 with no special path.

Reset
REQ-032 When rst=1 on a clock edge, the state SHALL become IDLE in any state, aborting any division and discarding any held result.
REQ-033 While rst=1 and on the first cycle after reset: in_ready=1, out_valid=0, time_out=0, early=0, sat=0 and busy=0.
REQ-034 rst SHALL take priority over any simultaneous handshake.

Configuration
REQ-035 Macro ETA_ROUND_EN SHALL control rounding of q.
REQ-036 With ETA_ROUND_EN defined, q SHALL be incremented by 1 in FIN when 2*remainder >= DIST_S1; this SHALL add no latency.
REQ-037 Without ETA_ROUND_EN, q SHALL be the truncated quotient and the remainder SHALL be unused.

Verification
REQ-038 Scenario: time_in=5000 -> time_out=49994, early=0, sat=0, out_valid exactly 38 cycles after accept, in both builds.
REQ-039 Scenario: time_in=2000 -> time_out=1997 without ETA_ROUND_EN, and 1998 with it.
REQ-040 Scenario: time_in=1000 and time_in=0 -> each gives time_out=0, early=1.
REQ-041 Scenario: time_in=524287 -> time_out=524287, sat=1.
REQ-042 Scenario: out_ready held 0 for 10 cycles in DONE -> out_valid, time_out and flags stay stable and in_ready=0; after out_ready=1, in_ready=1 one cycle after the handshake.
REQ-043 Scenario: rst pulsed in cycle 20 of DIV -> outputs match REQ-033, and a fresh time_in=5000 then yields 49994 with normal latency.
